// File: rtl/mux_arb_defs_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// Define MUX_ARB_LOCK_EN to add the REQ_LOCK port and owner locking.
package mux_arb_defs;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NREQ  = 4;

endpackage

// File: rtl/mux_2x1.sv
// Two-input data select cell used to build the winner steering tree.
module mux_2x1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible requester starting at i_ptr.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic [NREQ-1:0]  i_mask,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any
);

  logic [NREQ-1:0]  w_elig;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  assign w_elig = i_valid & i_mask;
  assign o_any  = |w_elig;

  // Walk ptr, ptr+1, ... with natural IDX_W-bit wrap.
  always_comb begin
    o_winner = i_ptr;
    w_found  = 1'b0;
    w_idx    = i_ptr;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!w_found && w_elig[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
      w_idx = w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among NREQ requesters.
// Optional owner locking is enabled with MUX_ARB_LOCK_EN.
module mux_rr_arbiter
  import mux_arb_defs::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NREQ  = DEF_NREQ,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*WIDTH-1:0] REQ_DATA,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NREQ-1:0]       REQ_LOCK,
`endif
  output logic [NREQ-1:0]       REQ_READY,
  output logic                  OUT_VALID,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic [IDX_W-1:0]      OUT_SRC,
  input  logic                  OUT_READY,
  output logic                  BUSY
);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_src;

  logic [NREQ-1:0]  w_mask;
  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic             w_load;
  logic             w_fire;
  logic [WIDTH-1:0] w_sel_data;

`ifdef MUX_ARB_LOCK_EN
  logic             r_lock;
  logic [IDX_W-1:0] r_owner;

  // A held lock restricts eligibility to the owner alone.
  assign w_mask = r_lock ? (NREQ'(1) << r_owner) : {NREQ{1'b1}};
`else
  assign w_mask = {NREQ{1'b1}};
`endif

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_valid  (REQ_VALID),
    .i_ptr    (r_ptr),
    .i_mask   (w_mask),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_load    = (r_state == IDLE) || OUT_READY;
  assign w_fire    = RSTn && w_load && w_any;
  assign REQ_READY = w_fire ? (NREQ'(1) << w_winner) : {NREQ{1'b0}};

  // Select tree: level l halves the candidates using winner bit l-1.
  for (genvar l = 0; l <= int'(IDX_W); l++) begin : g_lvl
    logic [WIDTH-1:0] w_lvl [NREQ >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < int'(NREQ); i++) begin : g_in
        assign w_lvl[i] = REQ_DATA[i*WIDTH +: WIDTH];
      end
    end else begin : g_node
      for (genvar j = 0; j < int'(NREQ >> l); j++) begin : g_mux
        mux_2x1 #(.WIDTH(WIDTH)) u_mux (
          .i_a   (g_lvl[l-1].w_lvl[2*j]),
          .i_b   (g_lvl[l-1].w_lvl[2*j+1]),
          .i_sel (w_winner[l-1]),
          .o_y   (w_lvl[j])
        );
      end
    end
  end

  assign w_sel_data = g_lvl[IDX_W].w_lvl[0];

  // Output register, pointer and state update.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_data  <= '0;
      r_src   <= '0;
`ifdef MUX_ARB_LOCK_EN
      r_lock  <= 1'b0;
      r_owner <= '0;
`endif
    end else if (w_fire) begin
      r_state <= HOLD;
      r_data  <= w_sel_data;
      r_src   <= w_winner;
`ifdef MUX_ARB_LOCK_EN
      if (REQ_LOCK[w_winner]) begin
        r_lock  <= 1'b1;
        r_owner <= w_winner;
      end else begin
        r_lock  <= 1'b0;
        r_ptr   <= w_winner + IDX_W'(1);
      end
`else
      r_ptr   <= w_winner + IDX_W'(1);
`endif
    end else if (OUT_READY) begin
      r_state <= IDLE;
    end
  end

  assign OUT_VALID = (r_state == HOLD);
  assign OUT_DATA  = r_data;
  assign OUT_SRC   = r_src;
  assign BUSY      = (r_state == HOLD) || (|REQ_VALID);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus queues expected beats, a monitor checks them.
module tb_mux_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [3:0]  REQ_VALID;
  logic [15:0] REQ_DATA;
  logic [3:0]  tb_lock;
  logic [3:0]  REQ_READY;
  logic        OUT_VALID;
  logic [3:0]  OUT_DATA;
  logic [1:0]  OUT_SRC;
  logic        OUT_READY;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];

  always #5 CLK = ~CLK;

  mux_rr_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
`ifdef MUX_ARB_LOCK_EN
    .REQ_LOCK  (tb_lock),
`endif
    .REQ_READY (REQ_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .OUT_SRC   (OUT_SRC),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs, check the grant, queue the expected beat, advance.
  task automatic cyc(input logic [3:0] v, input logic rdy, input logic [3:0] lk,
                     input logic [3:0] exp_rdy);
    logic [1:0] src;
    REQ_VALID = v;
    OUT_READY = rdy;
    tb_lock   = lk;
    #1;
    chk("req_ready", 32'(REQ_READY), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      src = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) src = 2'(i);
      sb.push_back({src, REQ_DATA[src*4 +: 4]});
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every transfer on the output side pops one expected beat.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge CLK);
      if (RSTn === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got src=%0d data=%0h expected no beat", OUT_SRC, OUT_DATA);
        end else begin
          e = sb.pop_front();
          chk("out_src", 32'(OUT_SRC), 32'(e[5:4]));
          chk("out_data", 32'(OUT_DATA), 32'(e[3:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RSTn      = 1'b0;
    REQ_VALID = 4'b1111;
    REQ_DATA  = {4'hA, 4'hB, 4'hC, 4'hD};
    tb_lock   = 4'b0000;
    OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_data", 32'(OUT_DATA), 32'd0);
    chk("rst_out_src", 32'(OUT_SRC), 32'd0);
    chk("rst_req_ready", 32'(REQ_READY), 32'd0);
    #1;
    RSTn = 1'b1;

    // Round-robin with all requesters valid.
    cyc(4'b1111, 1'b1, 4'b0000, 4'b0001);
    cyc(4'b1111, 1'b1, 4'b0000, 4'b0010);
    cyc(4'b1111, 1'b1, 4'b0000, 4'b0100);
    cyc(4'b1111, 1'b1, 4'b0000, 4'b1000);
    cyc(4'b1111, 1'b1, 4'b0000, 4'b0001);

    // Backpressure: beat from requester 0 held, no grants.
    for (int k = 0; k < 5; k++) begin
      REQ_VALID = 4'b0110;
      OUT_READY = 1'b0;
      #1;
      chk("bp_req_ready", 32'(REQ_READY), 32'd0);
      chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
      chk("bp_out_src", 32'(OUT_SRC), 32'd0);
      chk("bp_out_data", 32'(OUT_DATA), 32'hD);
      @(posedge CLK);
      #1;
    end
    cyc(4'b0110, 1'b1, 4'b0000, 4'b0010);
    cyc(4'b0110, 1'b1, 4'b0000, 4'b0100);

    // Pointer at 3, only requester 1 valid; pointer then lands on 2.
    cyc(4'b0010, 1'b1, 4'b0000, 4'b0010);
    cyc(4'b0110, 1'b1, 4'b0000, 4'b0100);

    // Drain after the requester 2 beat.
    cyc(4'b0000, 1'b1, 4'b0000, 4'b0000);
    chk("drain_out_valid", 32'(OUT_VALID), 32'd0);
    chk("drain_busy", 32'(BUSY), 32'd0);
    cyc(4'b0000, 1'b1, 4'b0000, 4'b0000);
    cyc(4'b1111, 1'b1, 4'b0000, 4'b1000);
    cyc(4'b0000, 1'b1, 4'b0000, 4'b0000);

`ifdef MUX_ARB_LOCK_EN
    cyc(4'b1010, 1'b1, 4'b0010, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b0010, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b0000, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b0000, 4'b1000);
    cyc(4'b0000, 1'b1, 4'b0000, 4'b0000);
`endif

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_out_valid", 32'(OUT_VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
